// File: rtl/dspl_capture.sv
`default_nettype none
// ============================================================================
//  Module   : dspl_capture
//  Purpose  : Snoops a multiplexed 8-digit 7-segment display bus and rebuilds
//             the {en, hex, dp} words the display driver was fed, one frame
//             per scan. Flags illegal anode states and undecodable patterns.
//  Revision : 1.0  initial release
// ============================================================================
module dspl_capture #(
   parameter int SETTLE   = 2,
   parameter int FRAME_TO = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  an,
   input  logic [7:0]  dec_ddp,
   output logic [47:0] digits,
   output logic        frame_valid,
   output logic        stable,
   output logic        err_an,
   output logic        err_seg
);

   // Hold counter only needs to reach SETTLE+1; reaching that value means the
   // selection has already been sampled and must not be sampled again.
   localparam int HW = $clog2(SETTLE + 2);
   localparam int TW = $clog2(FRAME_TO + 1);
   localparam logic [HW-1:0] c_HOLD_HIT = HW'(SETTLE);
   localparam logic [HW-1:0] c_HOLD_MAX = HW'(SETTLE + 1);
   localparam logic [TW-1:0] c_TO_LAST  = TW'(FRAME_TO - 1);

   logic [7:0]    an_prev_q;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] to_q, to_d;
   logic [47:0]   buf_q, buf_d;
   logic [47:0]   digits_q, digits_d;
   logic          nonempty_q, nonempty_d;
   logic [2:0]    last_q, last_d;
   logic          fv_q, fv_d;
   logic          stable_q, stable_d;
   logic          have_q, have_d;
   logic          err_an_q, err_an_d;
   logic          err_seg_q, err_seg_d;

   logic [7:0]    w_an_inv;
   logic          w_idle, w_onehot, w_bad;
   logic [2:0]    w_idx;
   logic [HW-1:0] w_hold_cur;
   logic [6:0]    w_seg;
   logic [3:0]    w_hex;
   logic          w_seg_ok;
   logic          w_sample, w_wrap, w_tmo, w_close;

   assign w_an_inv = ~an;
   assign w_idle   = (an == 8'hFF);
   assign w_onehot = (w_an_inv != 8'h00) && ((w_an_inv & (w_an_inv - 8'h01)) == 8'h00);
   assign w_bad    = !w_idle && !w_onehot;

   // Index of the single low anode bit (only meaningful when w_onehot).
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (w_an_inv[i]) w_idx = 3'(i);
      end
   end

   // Consecutive-cycle count of the current anode value, including this cycle.
   always_comb begin
      if (an != an_prev_q)            w_hold_cur = HW'(1);
      else if (hold_q == c_HOLD_MAX)  w_hold_cur = hold_q;
      else                            w_hold_cur = hold_q + HW'(1);
   end

   // Segment pattern (active-high, a = MSB) to hex value.
   always_comb begin
      w_seg    = ~dec_ddp[7:1];
      w_seg_ok = 1'b1;
      case (w_seg)
         7'h7E: w_hex = 4'h0;
         7'h30: w_hex = 4'h1;
         7'h6D: w_hex = 4'h2;
         7'h79: w_hex = 4'h3;
         7'h33: w_hex = 4'h4;
         7'h5B: w_hex = 4'h5;
         7'h5F: w_hex = 4'h6;
         7'h70: w_hex = 4'h7;
         7'h7F: w_hex = 4'h8;
         7'h7B: w_hex = 4'h9;
         7'h77: w_hex = 4'hA;
         7'h1F: w_hex = 4'hB;
         7'h4E: w_hex = 4'hC;
         7'h3D: w_hex = 4'hD;
         7'h4F: w_hex = 4'hE;
         7'h47: w_hex = 4'hF;
         default: begin
            w_hex    = 4'h0;
            w_seg_ok = 1'b0;
         end
      endcase
   end

   assign w_sample = w_onehot && (w_hold_cur == c_HOLD_HIT);
   assign w_wrap   = w_sample && nonempty_q && (w_idx <= last_q);
   assign w_tmo    = nonempty_q && (to_q == c_TO_LAST);
   assign w_close  = w_wrap || w_tmo;

   // Next-state: close snapshots the buffer before the current sample lands,
   // so a wrapping sample becomes the first entry of the fresh frame.
   always_comb begin
      buf_d = w_close ? 48'h0 : buf_q;
      if (w_sample) begin
         for (int i = 0; i < 8; i++) begin
            if (w_idx == 3'(i)) buf_d[6*i +: 6] = {1'b1, w_hex, ~dec_ddp[0]};
         end
      end
      nonempty_d = w_sample ? 1'b1 : (w_close ? 1'b0 : nonempty_q);
      last_d     = w_sample ? w_idx : last_q;
      if (w_sample || w_close)     to_d = '0;
      else if (to_q == c_TO_LAST)  to_d = to_q;
      else                         to_d = to_q + TW'(1);
      hold_d     = w_hold_cur;
      digits_d   = w_close ? buf_q : digits_q;
      fv_d       = w_close;
      stable_d   = w_close ? (have_q && (buf_q == digits_q)) : stable_q;
      have_d     = have_q | w_close;
      err_an_d   = err_an_q | w_bad;
      err_seg_d  = err_seg_q | (w_sample && !w_seg_ok);
   end

   // State registers, cleared asynchronously while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_prev_q  <= 8'hFF;
         hold_q     <= '0;
         to_q       <= '0;
         buf_q      <= '0;
         digits_q   <= '0;
         nonempty_q <= 1'b0;
         last_q     <= '0;
         fv_q       <= 1'b0;
         stable_q   <= 1'b0;
         have_q     <= 1'b0;
         err_an_q   <= 1'b0;
         err_seg_q  <= 1'b0;
      end else begin
         an_prev_q  <= an;
         hold_q     <= hold_d;
         to_q       <= to_d;
         buf_q      <= buf_d;
         digits_q   <= digits_d;
         nonempty_q <= nonempty_d;
         last_q     <= last_d;
         fv_q       <= fv_d;
         stable_q   <= stable_d;
         have_q     <= have_d;
         err_an_q   <= err_an_d;
         err_seg_q  <= err_seg_d;
      end
   end

   assign digits      = digits_q;
   assign frame_valid = fv_q;
   assign stable      = stable_q;
   assign err_an      = err_an_q;
   assign err_seg     = err_seg_q;

endmodule
`default_nettype wire
